// File: rtl/acesso_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cofre_pkg -- shared definitions for the safe access controller.
//   state_t      : controller FSM state encoding
//   PEN_S_DEF    : default lockout length in ticks
//   MAX_ERR_DEF  : default number of wrong attempts that raise the alarm
//   sat_inc2()   : 2-bit saturating increment for the error counter
// ---------------------------------------------------------------------------
package cofre_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EVAL    = 2'd1,
      LOCKOUT = 2'd2,
      ALARM   = 2'd3
   } state_t;

   localparam int PEN_S_DEF   = 5;
   localparam int MAX_ERR_DEF = 3;

   function automatic logic [1:0] sat_inc2(input logic [1:0] v);
      return (v == 2'd3) ? 2'd3 : v + 2'd1;
   endfunction

endpackage

// File: rtl/acesso_ctrl_timer.sv
// ---------------------------------------------------------------------------
// penalty_timer -- down-counter for the lockout penalty.
//   clk, reset : clock / synchronous active-high reset
//   clr        : synchronous clear (master key)
//   load       : load count with load_val (takes priority over tick)
//   load_val   : reload value
//   tick       : decrement strobe, ignored when count is already 0
//   count      : remaining ticks
//   done       : tick arriving while count==1, i.e. this edge expires it
// ---------------------------------------------------------------------------
module penalty_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic [W-1:0] count,
   output logic         done
);

   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (tick && (count != '0))
         count <= count - 1'b1;
   end

   // Lets the controller leave LOCKOUT on the same edge the count hits 0.
   assign done = tick && (count == W'(1));

endmodule

// File: rtl/acesso_ctrl.sv
// ---------------------------------------------------------------------------
// acesso_ctrl -- password attempt controller for the safe.
//   clk, reset : clock / synchronous active-high reset
//   tick       : 1 Hz enable strobe, drives the lockout countdown
//   try_req    : one-cycle submit pulse, senha_ok valid alongside it
//   senha_ok   : password comparison result
//   locked     : attempts only accepted while the safe is closed
//   H          : master key, clears lockout/alarm/error count
//   grant      : one-cycle open permission (cycle after a good try)
//   err_cnt    : consecutive wrong attempts
//   lockout    : penalty timer running
//   alarm      : sticky alarm after MAX_ERR wrong attempts
//   wait_s     : remaining lockout ticks (0 outside LOCKOUT)
// All outputs are decoded from registers only.
// ---------------------------------------------------------------------------
module acesso_ctrl
   import cofre_pkg::*;
#(
   parameter int PEN_S   = PEN_S_DEF,
   parameter int MAX_ERR = MAX_ERR_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       try_req,
   input  logic       senha_ok,
   input  logic       locked,
   input  logic       H,
   output logic       grant,
   output logic [1:0] err_cnt,
   output logic       lockout,
   output logic       alarm,
   output logic [3:0] wait_s
);

   localparam logic [3:0] PEN_V = 4'(PEN_S);
   localparam logic [1:0] MAX_V = 2'(MAX_ERR);

   state_t     state_q, state_d;
   logic       ok_q, ok_d;
   logic [1:0] err_q, err_d;
   logic [1:0] err_inc;
   logic       tmr_load, tmr_tick, tmr_done;
   logic [3:0] tmr_cnt;

   assign err_inc = sat_inc2(err_q);

   penalty_timer #(.W(4)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr      (H),
      .load     (tmr_load),
      .load_val (PEN_V),
      .tick     (tmr_tick),
      .count    (tmr_cnt),
      .done     (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ok_q    <= 1'b0;
         err_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   // H outranks everything except reset; a try_req alongside it is dropped.
   always_comb begin
      state_d  = state_q;
      ok_d     = ok_q;
      err_d    = err_q;
      tmr_load = 1'b0;
      tmr_tick = 1'b0;
      if (H) begin
         state_d = IDLE;
         ok_d    = 1'b0;
         err_d   = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (try_req && locked) begin
                  ok_d    = senha_ok;
                  state_d = EVAL;
               end
            end
            EVAL: begin
               ok_d = 1'b0;
               if (ok_q) begin
                  err_d   = 2'd0;
                  state_d = IDLE;
               end else begin
                  err_d = err_inc;
                  if (err_inc == MAX_V) begin
                     state_d = ALARM;
                  end else begin
                     state_d  = LOCKOUT;
                     tmr_load = 1'b1;
                  end
               end
            end
            LOCKOUT: begin
               tmr_tick = tick;
               if (tmr_done) state_d = IDLE;
            end
            ALARM:   state_d = ALARM;
            default: state_d = IDLE;
         endcase
      end
   end

   assign grant   = (state_q == EVAL) && ok_q;
   assign err_cnt = err_q;
   assign lockout = (state_q == LOCKOUT);
   assign alarm   = (state_q == ALARM);
   assign wait_s  = (state_q == LOCKOUT) ? tmr_cnt : 4'd0;

endmodule

// File: tb/tb_acesso_ctrl.sv
// Directed test for acesso_ctrl with default parameters (PEN_S=5, MAX_ERR=3).
module tb_acesso_ctrl;

   logic       clk = 1'b0;
   logic       reset, tick, try_req, senha_ok, locked, H;
   logic       grant, lockout, alarm;
   logic [1:0] err_cnt;
   logic [3:0] wait_s;

   int total = 0;
   int bad   = 0;

   acesso_ctrl dut (
      .clk(clk), .reset(reset), .tick(tick), .try_req(try_req),
      .senha_ok(senha_ok), .locked(locked), .H(H),
      .grant(grant), .err_cnt(err_cnt), .lockout(lockout),
      .alarm(alarm), .wait_s(wait_s)
   );

   always #5 clk = ~clk;

   // inputs applied before an edge, outputs expected just after it
   typedef struct packed {
      logic       rst, h, tk, tr, ok, lk;
      logic       g;
      logic [1:0] e;
      logic       lo, al;
      logic [3:0] w;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, h, tk, tr, ok, lk,
                      input logic g, input logic [1:0] e,
                      input logic lo, al, input logic [3:0] w);
      vec_t v;
      v.rst = rst; v.h = h; v.tk = tk; v.tr = tr; v.ok = ok; v.lk = lk;
      v.g = g; v.e = e; v.lo = lo; v.al = al; v.w = w;
      vq.push_back(v);
   endtask

   task automatic step(input logic rst, h, tk, tr, ok, lk);
      reset = rst; H = h; tick = tk; try_req = tr; senha_ok = ok; locked = lk;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic g, input logic [1:0] e,
                        input logic lo, al, input logic [3:0] w);
      total++;
      if ({grant, err_cnt, lockout, alarm, wait_s} !== {g, e, lo, al, w}) begin
         bad++;
         $display("FAIL %s: got grant=%b err=%0d lockout=%b alarm=%b wait=%0d, want grant=%b err=%0d lockout=%b alarm=%b wait=%0d",
                  nm, grant, err_cnt, lockout, alarm, wait_s, g, e, lo, al, w);
      end
   endtask

   initial begin
      reset = 1'b0; H = 1'b0; tick = 1'b0; try_req = 1'b0; senha_ok = 1'b0; locked = 1'b1;

      //   rst h tk tr ok lk   g  e lo al  w
      add(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // reset state
      add(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 1,   1, 0, 0, 0, 0);  // good try -> grant next cycle
      add(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // grant one cycle only
      add(0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0);  // wrong try -> EVAL
      add(0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 5);  // LOCKOUT loaded
      add(0, 0, 1, 0, 0, 1,   0, 1, 1, 0, 4);
      add(0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 4);  // no tick, hold
      add(0, 0, 1, 0, 0, 1,   0, 1, 1, 0, 3);
      add(0, 0, 0, 1, 1, 1,   0, 1, 1, 0, 3);  // try in LOCKOUT ignored
      add(0, 0, 0, 1, 1, 0,   0, 1, 1, 0, 3);  // locked=0, still counting
      add(0, 0, 1, 0, 0, 0,   0, 1, 1, 0, 2);  // counts with locked=0
      add(0, 0, 1, 0, 0, 1,   0, 1, 1, 0, 1);
      add(0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0);  // expire -> IDLE
      add(0, 0, 0, 1, 1, 0,   0, 1, 0, 0, 0);  // unlocked try ignored
      add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0);  // no EVAL entered
      add(0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0);  // tick in IDLE ignored
      add(0, 0, 0, 1, 0, 1,   0, 1, 0, 0, 0);  // second wrong
      add(0, 0, 0, 0, 0, 1,   0, 2, 1, 0, 5);
      add(0, 0, 1, 0, 0, 1,   0, 2, 1, 0, 4);
      add(0, 0, 1, 0, 0, 1,   0, 2, 1, 0, 3);
      add(0, 0, 1, 0, 0, 1,   0, 2, 1, 0, 2);
      add(0, 0, 1, 0, 0, 1,   0, 2, 1, 0, 1);
      add(0, 0, 1, 0, 0, 1,   0, 2, 0, 0, 0);
      add(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0);  // H + try at err=2
      add(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // try was discarded
      add(0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0);  // wrong #1
      add(0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 5);
      add(0, 0, 1, 0, 0, 1,   0, 1, 1, 0, 4);
      add(0, 0, 1, 0, 0, 1,   0, 1, 1, 0, 3);
      add(0, 0, 1, 0, 0, 1,   0, 1, 1, 0, 2);
      add(0, 0, 1, 0, 0, 1,   0, 1, 1, 0, 1);
      add(0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 1,   0, 1, 0, 0, 0);  // wrong #2
      add(0, 0, 0, 0, 0, 1,   0, 2, 1, 0, 5);
      add(0, 0, 1, 0, 0, 1,   0, 2, 1, 0, 4);
      add(0, 0, 1, 0, 0, 1,   0, 2, 1, 0, 3);
      add(0, 0, 1, 0, 0, 1,   0, 2, 1, 0, 2);
      add(0, 0, 1, 0, 0, 1,   0, 2, 1, 0, 1);
      add(0, 0, 1, 0, 0, 1,   0, 2, 0, 0, 0);
      add(0, 0, 0, 1, 0, 1,   0, 2, 0, 0, 0);  // wrong #3
      add(0, 0, 0, 0, 0, 1,   0, 3, 0, 1, 0);  // ALARM
      add(0, 0, 0, 1, 1, 1,   0, 3, 0, 1, 0);  // try ignored in ALARM
      add(0, 0, 1, 0, 0, 1,   0, 3, 0, 1, 0);  // tick ignored in ALARM
      add(0, 0, 0, 0, 0, 1,   0, 3, 0, 1, 0);
      add(0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // master key clears
      add(0, 0, 0, 1, 1, 1,   1, 0, 0, 0, 0);  // usable again
      add(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].rst, vq[i].h, vq[i].tk, vq[i].tr, vq[i].ok, vq[i].lk);
         check($sformatf("vec%0d", i), vq[i].g, vq[i].e, vq[i].lo, vq[i].al, vq[i].w);
      end

      // reset coincident with a good try: EVAL never entered, no grant
      step(1, 0, 0, 1, 1, 1); check("rst_try", 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1); check("rst_try_after", 0, 0, 0, 0, 0);

      // reset while in EVAL with a wrong try: err_cnt update suppressed
      step(0, 0, 0, 1, 0, 1); check("eval_wrong", 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1); check("rst_in_eval", 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1); check("rst_in_eval_after", 0, 0, 0, 0, 0);

      // reset mid-LOCKOUT: no residual count
      step(0, 0, 0, 1, 0, 1); check("lo_eval", 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1); check("lo_enter", 0, 1, 1, 0, 5);
      step(0, 0, 1, 0, 0, 1); check("lo_tick", 0, 1, 1, 0, 4);
      step(1, 0, 1, 0, 0, 1); check("rst_in_lockout", 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1); check("rst_in_lockout_tick", 0, 0, 0, 0, 0);

      // H during LOCKOUT: back to IDLE with wait_s cleared
      step(0, 0, 0, 1, 0, 1); check("h_eval", 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1); check("h_enter", 0, 1, 1, 0, 5);
      step(0, 1, 1, 0, 0, 1); check("h_in_lockout", 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 1); check("h_then_good", 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1); check("h_then_idle", 0, 0, 0, 0, 0);

      // reset while in ALARM
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 1, 0, 1);
         step(0, 0, 0, 0, 0, 1);
         if (k < 2) for (int t = 0; t < 5; t++) step(0, 0, 1, 0, 0, 1);
      end
      check("alarm_reached", 0, 3, 0, 1, 0);
      step(1, 0, 0, 0, 0, 1); check("rst_in_alarm", 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
